pilha_rpn_n: RTL and testbench

Parametrised RPN calculator stack with a real depth counter, validated push/execute handshake and a three-state execution FSM around an internal ALU. It replaces the fixed 4×8 shift stack in the calculator datapath. Depth and word width are configurable, and underflow, overflow and busy violations are detected. Front-panel logic drives it with single-cycle `push` and `executar` strobes and displays `topo`/`segundo`.

---
 rtl/pilha_rpn_n.sv | 219 +++++++++++++++++++++
 tb/tb_pilha_rpn_n.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pilha_rpn_n.sv
// Parametrised RPN stack with depth counter and a three-state execute FSM around an ALU.
// Define PILHA_RPN_MUL_EN to enable op 111 (unsigned multiply); otherwise that op is rejected.
module pilha_rpn_n #(
  parameter int LARGURA      = 8,
  parameter int PROFUNDIDADE = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [LARGURA-1:0]                entrada,
  input  logic                              push,
  input  logic                              executar,
  input  logic [2:0]                        operacao,
  input  logic                              limpar,
  output logic [LARGURA-1:0]                topo,
  output logic [LARGURA-1:0]                segundo,
  output logic [$clog2(PROFUNDIDADE+1)-1:0] contagem,
  output logic                              vazia,
  output logic                              cheia,
  output logic                              ocupado,
  output logic                              concluido,
  output logic                              zero,
  output logic                              carry_out,
  output logic                              overflow,
  output logic                              erro
);
  localparam int CW = $clog2(PROFUNDIDADE+1);
  localparam logic [CW-1:0] CONT_MAX = CW'(PROFUNDIDADE);
  localparam logic [CW-1:0] UM       = CW'(1);
  localparam logic [CW-1:0] DOIS     = CW'(2);
  localparam logic [LARGURA-1:0] MIN_NEG = {1'b1, {(LARGURA-1){1'b0}}};

  typedef enum logic [1:0] {OCIOSO, CALCULA, ESCREVE} estado_t;
  estado_t estado_reg, estado_next;

  logic [CW-1:0]      contagem_reg;
  logic [LARGURA-1:0] op_a_reg, op_b_reg, res_reg;
  logic [2:0]         op_reg;
  logic               zero_calc_reg, cy_calc_reg, ov_calc_reg;
  logic               zero_reg, cy_reg, ov_reg, erro_reg, concluido_reg;
  logic               exec_valido, aceita_exec, aceita_push, sinaliza_erro;
  logic               escreve, op_binario;

  // Operand-count and op-code legality for an incoming execute.
  always_comb begin
    exec_valido = 1'b0;
    case (operacao)
      3'b101, 3'b110: exec_valido = (contagem_reg >= UM);
`ifdef PILHA_RPN_MUL_EN
      3'b111:         exec_valido = (contagem_reg >= DOIS);
`else
      3'b111:         exec_valido = 1'b0;
`endif
      default:        exec_valido = (contagem_reg >= DOIS);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         estado_reg <= OCIOSO;
    else if (limpar) estado_reg <= OCIOSO;
    else             estado_reg <= estado_next;
  end

  always_comb begin
    estado_next   = estado_reg;
    aceita_exec   = 1'b0;
    aceita_push   = 1'b0;
    sinaliza_erro = 1'b0;
    case (estado_reg)
      OCIOSO: begin
        if (executar) begin
          if (exec_valido) begin
            aceita_exec = 1'b1;
            estado_next = CALCULA;
          end else begin
            sinaliza_erro = 1'b1;
          end
          if (push) sinaliza_erro = 1'b1;
        end else if (push) begin
          if (contagem_reg == CONT_MAX) sinaliza_erro = 1'b1;
          else                          aceita_push   = 1'b1;
        end
      end
      CALCULA: begin
        estado_next   = ESCREVE;
        sinaliza_erro = push | executar;
      end
      ESCREVE: begin
        estado_next   = OCIOSO;
        sinaliza_erro = push | executar;
      end
      default: estado_next = OCIOSO;
    endcase
  end

  assign escreve    = (estado_reg == ESCREVE);
  assign op_binario = !((op_reg == 3'b101) || (op_reg == 3'b110));

  // ALU: op_a is the latched second entry, op_b the latched top.
  logic [LARGURA:0]   soma, dif;
  logic [LARGURA-1:0] alu_res;
  logic               alu_cy, alu_ov;
  assign soma = {1'b0, op_a_reg} + {1'b0, op_b_reg};
  assign dif  = {1'b0, op_a_reg} - {1'b0, op_b_reg};
`ifdef PILHA_RPN_MUL_EN
  logic [2*LARGURA-1:0] produto;
  assign produto = {{LARGURA{1'b0}}, op_a_reg} * {{LARGURA{1'b0}}, op_b_reg};
`endif

  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    alu_ov  = 1'b0;
    case (op_reg)
      3'b000: begin
        alu_res = soma[LARGURA-1:0];
        alu_cy  = soma[LARGURA];
        alu_ov  = (op_a_reg[LARGURA-1] == op_b_reg[LARGURA-1]) &&
                  (soma[LARGURA-1] != op_a_reg[LARGURA-1]);
      end
      3'b001: begin
        alu_res = dif[LARGURA-1:0];
        alu_cy  = dif[LARGURA];
        alu_ov  = (op_a_reg[LARGURA-1] != op_b_reg[LARGURA-1]) &&
                  (dif[LARGURA-1] != op_a_reg[LARGURA-1]);
      end
      3'b010: alu_res = op_a_reg & op_b_reg;
      3'b011: alu_res = op_a_reg | op_b_reg;
      3'b100: alu_res = op_a_reg ^ op_b_reg;
      3'b101: alu_res = ~op_b_reg;
      3'b110: begin
        alu_res = LARGURA'(0) - op_b_reg;
        alu_ov  = (op_b_reg == MIN_NEG);
      end
`ifdef PILHA_RPN_MUL_EN
      3'b111: begin
        alu_res = produto[LARGURA-1:0];
        alu_ov  = |produto[2*LARGURA-1:LARGURA];
      end
`endif
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || limpar) begin
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      op_reg        <= '0;
      res_reg       <= '0;
      zero_calc_reg <= 1'b0;
      cy_calc_reg   <= 1'b0;
      ov_calc_reg   <= 1'b0;
      zero_reg      <= 1'b0;
      cy_reg        <= 1'b0;
      ov_reg        <= 1'b0;
      erro_reg      <= 1'b0;
      concluido_reg <= 1'b0;
      contagem_reg  <= '0;
    end else begin
      concluido_reg <= escreve;
      if (sinaliza_erro) erro_reg <= 1'b1;
      if (aceita_exec) begin
        op_a_reg <= segundo;
        op_b_reg <= topo;
        op_reg   <= operacao;
      end
      if (estado_reg == CALCULA) begin
        res_reg       <= alu_res;
        zero_calc_reg <= (alu_res == '0);
        cy_calc_reg   <= alu_cy;
        ov_calc_reg   <= alu_ov;
      end
      if (escreve) begin
        zero_reg <= zero_calc_reg;
        cy_reg   <= cy_calc_reg;
        ov_reg   <= ov_calc_reg;
        if (op_binario) contagem_reg <= contagem_reg - UM;
      end else if (aceita_push) begin
        contagem_reg <= contagem_reg + UM;
      end
    end
  end

  // Each entry loads from above on push and from below on a binary write-back.
  genvar gi;
  generate
    for (gi = 0; gi < PROFUNDIDADE; gi++) begin : gen_pilha
      logic [LARGURA-1:0] valor_reg, vem_cima, valor_esc;
      if (gi == 0) begin : g_topo
        assign vem_cima  = entrada;
        assign valor_esc = res_reg;
      end else if (gi == PROFUNDIDADE-1) begin : g_fundo
        assign vem_cima  = gen_pilha[gi-1].valor_reg;
        assign valor_esc = op_binario ? '0 : valor_reg;
      end else begin : g_meio
        assign vem_cima  = gen_pilha[gi-1].valor_reg;
        assign valor_esc = op_binario ? gen_pilha[gi+1].valor_reg : valor_reg;
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst)              valor_reg <= '0;
        else if (limpar)      valor_reg <= '0;
        else if (aceita_push) valor_reg <= vem_cima;
        else if (escreve)     valor_reg <= valor_esc;
      end
    end
  endgenerate

  assign topo      = gen_pilha[0].valor_reg;
  assign segundo   = gen_pilha[1].valor_reg;
  assign contagem  = contagem_reg;
  assign vazia     = (contagem_reg == '0);
  assign cheia     = (contagem_reg == CONT_MAX);
  assign ocupado   = (estado_reg != OCIOSO);
  assign concluido = concluido_reg;
  assign zero      = zero_reg;
  assign carry_out = cy_reg;
  assign overflow  = ov_reg;
  assign erro      = erro_reg;
endmodule

// File: tb/tb_pilha_rpn_n.sv
// Directed self-checking bench for pilha_rpn_n (LARGURA=8, PROFUNDIDADE=4).
module tb_pilha_rpn_n;
  logic       clk, rst, push, executar, limpar;
  logic [7:0] entrada, topo, segundo;
  logic [2:0] operacao, contagem;
  logic       vazia, cheia, ocupado, concluido, zero, carry_out, overflow, erro;
  int n_cmp = 0;
  int n_err = 0;

  pilha_rpn_n #(.LARGURA(8), .PROFUNDIDADE(4)) dut (
    .clk(clk), .rst(rst), .entrada(entrada), .push(push), .executar(executar),
    .operacao(operacao), .limpar(limpar), .topo(topo), .segundo(segundo),
    .contagem(contagem), .vazia(vazia), .cheia(cheia), .ocupado(ocupado),
    .concluido(concluido), .zero(zero), .carry_out(carry_out),
    .overflow(overflow), .erro(erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_push(input logic [7:0] v);
    @(negedge clk); push = 1'b1; entrada = v;
    @(posedge clk); #1; push = 1'b0;
    $display("push %0h -> topo %0h contagem %0d", v, topo, contagem);
  endtask

  task automatic do_limpar();
    @(negedge clk); limpar = 1'b1;
    @(posedge clk); #1; limpar = 1'b0;
    $display("limpar -> contagem %0d", contagem);
  endtask

  // Valid execute with full handshake timing checks.
  task automatic exec_ok(input logic [2:0] op);
    @(negedge clk); executar = 1'b1; operacao = op;
    @(posedge clk); #1; executar = 1'b0;
    chk("ocupado_T", ocupado, 1);
    chk("concluido_T", concluido, 0);
    @(posedge clk); #1;
    chk("ocupado_T1", ocupado, 1);
    @(posedge clk); #1;
    chk("concluido_T2", concluido, 1);
    chk("ocupado_T2", ocupado, 0);
    $display("exec %b -> topo %0h contagem %0d z%b c%b v%b", op, topo, contagem, zero, carry_out, overflow);
    @(posedge clk); #1;
    chk("concluido_pulso", concluido, 0);
  endtask

  task automatic exec_inv(input logic [2:0] op);
    @(negedge clk); executar = 1'b1; operacao = op;
    @(posedge clk); #1; executar = 1'b0;
    chk("inv_ocupado", ocupado, 0);
    chk("inv_erro", erro, 1);
    $display("exec %b rejected -> erro %b", op, erro);
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; executar = 1'b0; limpar = 1'b0;
    entrada = '0; operacao = '0;
    #12;
    chk("rst_contagem", contagem, 0);
    chk("rst_vazia", vazia, 1);
    chk("rst_cheia", cheia, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_concluido", concluido, 0);
    chk("rst_erro", erro, 0);
    chk("rst_topo", topo, 0);
    chk("rst_flags", {zero, carry_out, overflow}, 0);
    @(negedge clk); rst = 1'b0;

    // 5 - 3
    do_push(8'd5);
    do_push(8'd3);
    chk("push_topo", topo, 3);
    chk("push_segundo", segundo, 5);
    chk("push_contagem", contagem, 2);
    exec_ok(3'b001);
    chk("sub_topo", topo, 2);
    chk("sub_contagem", contagem, 1);
    chk("sub_segundo", segundo, 0);
    chk("sub_carry", carry_out, 0);
    chk("sub_zero", zero, 0);
    chk("sub_erro", erro, 0);

    // Signed overflow on add, then neg of the minimum
    do_limpar();
    do_push(8'h7F);
    do_push(8'h01);
    exec_ok(3'b000);
    chk("add_topo", topo, 8'h80);
    chk("add_ov", overflow, 1);
    chk("add_cy", carry_out, 0);
    chk("add_contagem", contagem, 1);
    exec_ok(3'b110);
    chk("neg_topo", topo, 8'h80);
    chk("neg_ov", overflow, 1);
    chk("neg_contagem", contagem, 1);

    // Overflow of the stack
    do_limpar();
    do_push(8'd1); do_push(8'd2); do_push(8'd3); do_push(8'd4);
    chk("full_cheia", cheia, 1);
    chk("full_erro_antes", erro, 0);
    do_push(8'd5);
    chk("full_erro", erro, 1);
    chk("full_topo", topo, 4);
    chk("full_segundo", segundo, 3);
    chk("full_contagem", contagem, 4);
    do_limpar();
    chk("clr_contagem", contagem, 0);
    chk("clr_vazia", vazia, 1);
    chk("clr_erro", erro, 0);
    chk("clr_topo", topo, 0);

    // Underflow on binary op, then unary not
    do_push(8'd9);
    exec_inv(3'b000);
    chk("under_topo", topo, 9);
    chk("under_contagem", contagem, 1);
    do_limpar();
    do_push(8'd9);
    exec_ok(3'b101);
    chk("not_topo", topo, 8'hF6);
    chk("not_contagem", contagem, 1);

    // Borrow with a third entry shifting up
    do_push(8'd3);
    do_push(8'd5);
    exec_ok(3'b001);
    chk("borrow_topo", topo, 8'hFE);
    chk("borrow_cy", carry_out, 1);
    chk("borrow_ov", overflow, 0);
    chk("borrow_segundo", segundo, 8'hF6);
    chk("borrow_contagem", contagem, 2);
    do_push(8'hFE);
    exec_ok(3'b100);
    chk("xor_topo", topo, 0);
    chk("xor_zero", zero, 1);
    chk("xor_cy", carry_out, 0);
    chk("xor_segundo", segundo, 8'hF6);
    chk("xor_contagem", contagem, 2);

    // Multiply
    do_limpar();
    do_push(8'd6);
    do_push(8'd7);
`ifdef PILHA_RPN_MUL_EN
    exec_ok(3'b111);
    chk("mul_topo", topo, 8'd42);
    chk("mul_contagem", contagem, 1);
`else
    exec_inv(3'b111);
    chk("mul_topo", topo, 8'd7);
    chk("mul_contagem", contagem, 2);
`endif

    // Async reset while in CALCULA
    do_limpar();
    do_push(8'd1);
    do_push(8'd2);
    @(negedge clk); executar = 1'b1; operacao = 3'b000;
    @(posedge clk); #1; executar = 1'b0;
    chk("rstmid_ocupado_antes", ocupado, 1);
    #1; rst = 1'b1;
    #1;
    chk("rstmid_ocupado", ocupado, 0);
    chk("rstmid_contagem", contagem, 0);
    chk("rstmid_topo", topo, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rstmid_sem_concluido", concluido, 0);
    end
    $display("reset during CALCULA -> topo %0h contagem %0d", topo, contagem);

    // Push while busy is ignored and flagged
    do_push(8'd4);
    do_push(8'd5);
    @(negedge clk); executar = 1'b1; operacao = 3'b011;
    @(posedge clk); #1; executar = 1'b0;
    @(negedge clk); push = 1'b1; entrada = 8'h33;
    @(posedge clk); #1; push = 1'b0;
    chk("busy_ocupado", ocupado, 1);
    chk("busy_erro", erro, 1);
    @(posedge clk); #1;
    chk("busy_concluido", concluido, 1);
    chk("busy_topo", topo, 8'd5);
    chk("busy_segundo", segundo, 0);
    chk("busy_contagem", contagem, 1);
    $display("push while busy -> topo %0h erro %b", topo, erro);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
